q_episode_controller: RTL

//  Sequences one tabular Q-learning agent on a GRID_W x GRID_W maze. Each step it reads the

---
 rtl/q_episode_controller.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/q_episode_controller.sv
// Episode sequencer for one tabular Q-learning agent on a GRID_W x GRID_W maze.
// Drives Q-table reads/writes and the action selector, and tracks steps, episodes and epsilon.
//
// state   | meaning
// IDLE    | waiting for start after reset
// RD_CUR  | issue read of the current-state Q row
// LAT_CUR | latch current row for the action selector
// SELECT  | latch selector action
// MOVE    | compute next state and reward, issue next-row read
// LAT_NXT | latch max Q of the next row (0 when terminal)
// UPDATE  | write back the updated Q row
// CHECK   | advance step/episode counters, decay epsilon
// DONE    | run finished, waiting for start
module q_episode_controller #(
    parameter int GRID_W       = 4,
    parameter int START_STATE  = 0,
    parameter int GOAL_STATE   = 15,
    parameter int R_GOAL       = 100,
    parameter int R_PIT        = 100,
    parameter int R_STEP       = 1,
    parameter int ALPHA_SH     = 2,
    parameter int GAMMA_SH     = 1,
    parameter int MAX_STEPS    = 64,
    parameter int NUM_EPISODES = 300,
    parameter int EPS_DEC      = 218
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] pit_map,
    output logic [3:0]  q_rd_addr,
    input  logic [63:0] q_rd_data,
    output logic        q_wr_en,
    output logic [3:0]  q_wr_addr,
    output logic [63:0] q_wr_data,
    output logic        sel_start,
    output logic [63:0] sel_q_values,
    output logic [15:0] sel_epsilon,
    input  logic [3:0]  sel_action,
    output logic [3:0]  cur_state,
    output logic [6:0]  step_cnt,
    output logic [15:0] episode_cnt,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_CUR,
        S_LAT_CUR,
        S_SELECT,
        S_MOVE,
        S_LAT_NXT,
        S_UPDATE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [3:0]         cur_q;
    logic [6:0]         step_q;
    logic [15:0]        ep_q;
    logic [15:0]        eps_q;
    logic [15:0]        pits_q;
    logic               done_q;
    logic               sel_start_q;
    logic [63:0]        row_q;
    logic [1:0]         act_q;
    logic [3:0]         nxt_q;
    logic signed [17:0] reward_q;
    logic               term_q;
    logic signed [17:0] maxq_q;

    function automatic logic signed [17:0] sm_to_tc(input logic [15:0] v);
        logic signed [17:0] mag;
        mag = {3'b000, v[14:0]};
        return v[15] ? -mag : mag;
    endfunction

    // Input is already saturated to +/-32767, so a negative value never encodes as -0.
    function automatic logic [15:0] tc_to_sm(input logic signed [19:0] v);
        logic signed [19:0] neg_v;
        neg_v = -v;
        return v[19] ? {1'b1, neg_v[14:0]} : {1'b0, v[14:0]};
    endfunction

    // Move decode
    int          cur_i;
    int          row_i;
    int          col_i;
    int          nxt_i;
    logic [3:0]  mv_next;
    logic        mv_blocked;
    logic        mv_goal;
    logic        mv_pit;
    logic signed [17:0] mv_reward;

    always_comb begin
        cur_i      = int'(cur_q);
        row_i      = cur_i / GRID_W;
        col_i      = cur_i % GRID_W;
        nxt_i      = cur_i;
        mv_blocked = 1'b0;
        case (act_q)
            2'd0:    if (row_i > 0)          nxt_i = cur_i - GRID_W; else mv_blocked = 1'b1;
            2'd1:    if (row_i < GRID_W - 1) nxt_i = cur_i + GRID_W; else mv_blocked = 1'b1;
            2'd2:    if (col_i > 0)          nxt_i = cur_i - 1;      else mv_blocked = 1'b1;
            default: if (col_i < GRID_W - 1) nxt_i = cur_i + 1;      else mv_blocked = 1'b1;
        endcase
        mv_next = 4'(nxt_i);
        mv_goal = !mv_blocked && (mv_next == 4'(GOAL_STATE));
        mv_pit  = !mv_blocked && !mv_goal && pits_q[mv_next];
        if (mv_goal)
            mv_reward = 18'(R_GOAL);
        else if (mv_pit)
            mv_reward = -18'(R_PIT);
        else
            mv_reward = -18'(R_STEP);
    end

    logic signed [17:0] row_max;
    logic signed [17:0] cand;

    always_comb begin
        row_max = sm_to_tc(q_rd_data[15:0]);
        cand    = '0;
        for (int i = 1; i < 4; i++) begin
            cand = sm_to_tc(q_rd_data[i*16 +: 16]);
            if (cand > row_max)
                row_max = cand;
        end
    end

    // Q update, 20-bit internal so the sum cannot wrap before saturation
    logic signed [19:0] r20;
    logic signed [19:0] m20;
    logic signed [19:0] q20;
    logic signed [19:0] t20;
    logic signed [19:0] nq20;
    logic [15:0]        new_sm;
    logic [63:0]        wr_row;

    always_comb begin
        r20  = reward_q;
        m20  = maxq_q;
        q20  = sm_to_tc(row_q[int'(act_q)*16 +: 16]);
        t20  = r20 + m20 - (m20 >>> GAMMA_SH) - q20;
        nq20 = q20 + (t20 >>> ALPHA_SH);
        if (nq20 > 20'sd32767)
            nq20 = 20'sd32767;
        else if (nq20 < -20'sd32767)
            nq20 = -20'sd32767;
        new_sm = tc_to_sm(nq20);
        wr_row = row_q;
        wr_row[int'(act_q)*16 +: 16] = new_sm;
    end

    logic [6:0]  step_inc;
    logic [15:0] ep_inc;
    logic        ep_end;
    logic        run_end;

    always_comb begin
        step_inc = step_q + 7'd1;
        ep_inc   = ep_q + 16'd1;
        ep_end   = term_q || (step_inc == 7'(MAX_STEPS));
        run_end  = ep_end && (ep_inc == 16'(NUM_EPISODES));
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_RD_CUR;
            S_RD_CUR:       state_nxt = S_LAT_CUR;
            S_LAT_CUR:      state_nxt = S_SELECT;
            S_SELECT:       state_nxt = S_MOVE;
            S_MOVE:         state_nxt = S_LAT_NXT;
            S_LAT_NXT:      state_nxt = S_UPDATE;
            S_UPDATE:       state_nxt = S_CHECK;
            S_CHECK:        state_nxt = run_end ? S_DONE : S_RD_CUR;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q       <= 4'(START_STATE);
            step_q      <= '0;
            ep_q        <= '0;
            eps_q       <= 16'hFFFF;
            pits_q      <= '0;
            done_q      <= 1'b0;
            sel_start_q <= 1'b0;
            row_q       <= '0;
            act_q       <= '0;
            nxt_q       <= '0;
            reward_q    <= '0;
            term_q      <= 1'b0;
            maxq_q      <= '0;
        end else begin
            sel_start_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cur_q       <= 4'(START_STATE);
                        step_q      <= '0;
                        ep_q        <= '0;
                        eps_q       <= 16'hFFFF;
                        pits_q      <= pit_map;
                        done_q      <= 1'b0;
                        sel_start_q <= 1'b1;
                    end
                end
                S_LAT_CUR: row_q <= q_rd_data;
                S_SELECT: begin
                    if (sel_action == 4'd0 || sel_action > 4'd4)
                        act_q <= 2'd0;
                    else
                        act_q <= 2'(sel_action - 4'd1);
                end
                S_MOVE: begin
                    nxt_q    <= mv_next;
                    reward_q <= mv_reward;
                    term_q   <= mv_goal || mv_pit;
                end
                S_LAT_NXT: maxq_q <= term_q ? 18'sd0 : row_max;
                S_CHECK: begin
                    if (ep_end) begin
                        ep_q   <= ep_inc;
                        eps_q  <= (eps_q < 16'(EPS_DEC)) ? 16'h0000 : eps_q - 16'(EPS_DEC);
                        cur_q  <= 4'(START_STATE);
                        step_q <= '0;
                        if (run_end)
                            done_q <= 1'b1;
                    end else begin
                        cur_q  <= nxt_q;
                        step_q <= step_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        q_rd_addr = 4'd0;
        if (state == S_RD_CUR)
            q_rd_addr = cur_q;
        else if (state == S_MOVE)
            q_rd_addr = mv_next;
    end

    // Gated by rst so an abort landing on UPDATE never corrupts the table.
    assign q_wr_en      = (state == S_UPDATE) && !rst;
    assign q_wr_addr    = cur_q;
    assign q_wr_data    = (state == S_UPDATE) ? wr_row : 64'd0;
    assign sel_start    = sel_start_q;
    assign sel_q_values = row_q;
    assign sel_epsilon  = eps_q;
    assign cur_state    = cur_q;
    assign step_cnt     = step_q;
    assign episode_cnt  = ep_q;
    assign busy         = (state != S_IDLE) && (state != S_DONE);
    assign done         = done_q;

endmodule
